// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter with a scan-code FIFO and a self-generated PS/2 clock.
// Optional host-inhibit detection on ps2_clk_in is enabled by defining PS2_TX_INHIBIT_EN.
module ps2_kbd_tx #(
    parameter int CLKDIV     = 1923,
    parameter int FIFO_AW    = 4,
    parameter int GAP_HALVES = 2
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [7:0]       code_in,
    input  logic             code_valid,
    output logic             code_ready,
    output logic             ps2_clk_out,
    output logic             ps2_dat_out,
    output logic             busy,
    output logic [FIFO_AW:0] fifo_count
`ifdef PS2_TX_INHIBIT_EN
    ,
    input  logic             ps2_clk_in
`endif
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = $clog2(CLKDIV);
    localparam int GW    = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(CLKDIV - 1);
    localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_HALVES - 1);
    localparam logic [FIFO_AW:0] FULL     = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
    } state_t;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ready_q;
    logic               push, pop;

    state_t             state_q, state_d;
    logic               phase_q, phase_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               clk_q, clk_d;
    logic               dat_q, dat_d;
    logic               busy_q, busy_d;
    logic               last;
    logic [2:0]         nb;
    logic [7:0]         head;
    logic               start_ok;

    assign push        = code_valid & ready_q;
    assign head        = mem_q[rd_ptr_q];
    assign code_ready  = ready_q;
    assign ps2_clk_out = clk_q;
    assign ps2_dat_out = dat_q;
    assign busy        = busy_q;
    assign fifo_count  = count_q;

`ifdef PS2_TX_INHIBIT_EN
    localparam int HW = $clog2(2 * CLKDIV + 1);
    localparam logic [HW-1:0] HI_MAX = HW'(2 * CLKDIV);
    logic [1:0]    sync_q;
    logic [HW-1:0] hi_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
            hi_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], ps2_clk_in};
            if (!sync_q[1])
                hi_q <= '0;
            else if (hi_q != HI_MAX)
                hi_q <= hi_q + 1'b1;
        end
    end

    assign start_ok = (hi_q == HI_MAX);
`else
    assign start_ok = 1'b1;
`endif

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push)
            mem_q[wr_ptr_q] <= code_in;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ready_q <= (count_d != FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        clk_d   = clk_q;
        dat_d   = dat_q;
        busy_d  = busy_q;
        pop     = 1'b0;
        last    = (cnt_q == CNT_LAST);
        nb      = bit_q + 3'd1;
        unique case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                phase_d = 1'b0;
                if (count_q != '0 && start_ok) begin
                    state_d = S_START;
                    clk_d   = 1'b1;
                    dat_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_GAP: begin
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: begin
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    phase_d = ~phase_q;
                    clk_d   = phase_q;
                    // End of phase B: advance to the next bit, dat changes with clk rising
                    if (phase_q) begin
                        case (state_q)
                            S_START: begin
                                state_d = S_DATA;
                                bit_d   = 3'd0;
                                dat_d   = head[0];
                            end
                            S_DATA: begin
                                if (bit_q == 3'd7) begin
                                    state_d = S_PARITY;
                                    dat_d   = ~^head;
                                end else begin
                                    bit_d = nb;
                                    dat_d = head[nb];
                                end
                            end
                            S_PARITY: begin
                                state_d = S_STOP;
                                dat_d   = 1'b1;
                            end
                            S_STOP: begin
                                state_d = S_GAP;
                                dat_d   = 1'b1;
                                gap_d   = '0;
                                pop     = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
`ifdef PS2_TX_INHIBIT_EN
        if (!sync_q[1] && (state_q == S_GAP ||
            (state_q != S_IDLE && !phase_q))) begin
            state_d = S_IDLE;
            phase_d = 1'b0;
            cnt_d   = '0;
            clk_d   = 1'b1;
            dat_d   = 1'b1;
            busy_d  = 1'b0;
            pop     = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            clk_q   <= 1'b1;
            dat_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            clk_q   <= clk_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
        end
    end

endmodule
